dot_matrix_scan_scheduler: RTL and testbench



---
 rtl/dot_matrix_scan_scheduler_pkg.sv | 20 ++
 rtl/dot_matrix_scan_scheduler_if.sv | 21 ++
 rtl/dot_matrix_scan_scheduler_prescaler.sv | 24 ++
 rtl/dot_matrix_scan_scheduler.sv | 108 ++++++++++
 tb/tb_dot_matrix_scan_scheduler.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dot_matrix_scan_scheduler_pkg.sv
// Shared constants and types for the dot-matrix frame store and row scanner.
package dot_matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [7:0] ROW_OFF = 8'hFF;
  localparam logic [7:0] COL_OFF = 8'h00;

  typedef logic [2:0] row_idx_t;
  typedef logic [7:0] row_bits_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PEND
  } swap_state_t;

  // Active-low one-hot row select; row 0 sits on bit 7.
  function automatic row_bits_t row_select(input row_idx_t idx);
    return ~(8'h80 >> idx);
  endfunction
endpackage

// File: rtl/dot_matrix_scan_scheduler_if.sv
// Host-side write/commit port of the dot-matrix scan scheduler.
interface dot_matrix_scan_scheduler_if;
  import dot_matrix_pkg::*;

  logic      wr_valid;
  logic      wr_ready;
  row_idx_t  wr_row;
  row_bits_t wr_data;
  logic      commit;
  logic      commit_pending;

  modport master (
    output wr_valid, wr_row, wr_data, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_row, wr_data, commit,
    output wr_ready, commit_pending
  );
endinterface

// File: rtl/dot_matrix_scan_scheduler_prescaler.sv
// Row-slot prescaler: counts 0..SCAN_DIV-1, tick on the last count.
module scan_prescaler #(
  parameter int SCAN_DIV = 2500,
  parameter int CW       = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          tick,
  output logic [CW-1:0] count
);
  logic [CW-1:0] count_d, count_q;

  always_comb begin
    tick    = (count_q == CW'(SCAN_DIV - 1));
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/dot_matrix_scan_scheduler.sv
// Double-buffered 8x8 frame store with tear-free bank swap and row scan.
// Optional anti-ghost row blanking: define DOT_MATRIX_ROW_BLANK_EN.
module dot_matrix_scan_scheduler
  import dot_matrix_pkg::*;
#(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  dot_matrix_scan_scheduler_if.slave  host,
  output logic                        frame_start,
  output row_bits_t                   dot_row,
  output row_bits_t                   dot_column
);
  localparam int CW = $clog2(SCAN_DIV);

  logic          tick;
  logic [CW-1:0] count;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV), .CW(CW)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .count (count)
  );

  swap_state_t state_d, state_q;
  logic        front_sel_d, front_sel_q;
  row_idx_t    row_idx_d, row_idx_q;
  row_bits_t   dot_row_d, dot_row_q;
  row_bits_t   dot_column_d, dot_column_q;
  logic        frame_start_d, frame_start_q;
  row_bits_t [1:0][ROWS-1:0] bank_d, bank_q;

  row_idx_t next_idx;
  logic     boundary;
  logic     swap;
  logic     wr_acc;

  // Swap FSM: the pending flag is the state, so writes and swaps never overlap.
  always_comb begin
    state_d  = state_q;
    swap     = 1'b0;
    boundary = tick && (row_idx_q == 3'd7);
    case (state_q)
      SWAP_IDLE: if (host.commit) state_d = SWAP_PEND;
      SWAP_PEND: if (boundary) begin
        state_d = SWAP_IDLE;
        swap    = 1'b1;
      end
      default:   state_d = SWAP_IDLE;
    endcase
  end

  always_comb begin
    front_sel_d   = front_sel_q ^ swap;
    wr_acc        = host.wr_valid && (state_q == SWAP_IDLE);
    bank_d        = bank_q;
    if (wr_acc) bank_d[~front_sel_q][host.wr_row] = host.wr_data;

    next_idx      = row_idx_q + 3'd1;
    row_idx_d     = row_idx_q;
    dot_row_d     = dot_row_q;
    dot_column_d  = dot_column_q;
    frame_start_d = boundary;
    // Row 0 of a swapping frame must read the new front bank.
    if (tick) begin
      row_idx_d    = next_idx;
      dot_row_d    = row_select(next_idx);
      dot_column_d = bank_q[front_sel_d][next_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SWAP_IDLE;
      front_sel_q   <= 1'b0;
      row_idx_q     <= 3'd7;
      dot_row_q     <= ROW_OFF;
      dot_column_q  <= COL_OFF;
      frame_start_q <= 1'b0;
      bank_q        <= '0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      row_idx_q     <= row_idx_d;
      dot_row_q     <= dot_row_d;
      dot_column_q  <= dot_column_d;
      frame_start_q <= frame_start_d;
      bank_q        <= bank_d;
    end
  end

  assign host.wr_ready       = (state_q == SWAP_IDLE);
  assign host.commit_pending = (state_q == SWAP_PEND);
  assign frame_start         = frame_start_q;
  assign dot_column          = dot_column_q;

`ifdef DOT_MATRIX_ROW_BLANK_EN
  // Column data settles while every row is off at the start of each slot.
  assign dot_row = (count < CW'(BLANK_CYCLES)) ? ROW_OFF : dot_row_q;
`else
  logic unused_blank;
  assign unused_blank = ^{count, (BLANK_CYCLES != 0)};
  assign dot_row      = dot_row_q;
`endif
endmodule

// File: tb/tb_dot_matrix_scan_scheduler.sv
// Self-checking bench: directed steps plus random host traffic vs a frame-level model.
module tb_dot_matrix_scan_scheduler;
`ifdef DOT_MATRIX_ROW_BLANK_EN
  localparam int D  = 20;
  localparam int BL = 4;
`else
  localparam int D  = 4;
  localparam int BL = 0;
`endif

  logic       clk, reset;
  logic       frame_start;
  logic [7:0] dot_row, dot_column;

  dot_matrix_scan_scheduler_if hif();

  dot_matrix_scan_scheduler #(.SCAN_DIV(D), .BLANK_CYCLES(BL)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (hif),
    .frame_start (frame_start),
    .dot_row     (dot_row),
    .dot_column  (dot_column)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Model: what each bank holds as a picture, and time since reset release.
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];
  bit         m_pend;
  int         k;
  logic [7:0] e_row, e_col;
  bit         e_fs;

  logic [7:0] glyph [8] = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};

  task automatic model_edge();
    bit tick, bnd, acc;
    int row;
    logic [7:0] tmp;
    if (reset) begin
      k = 0;
      for (int r = 0; r < 8; r++) begin m_front[r] = 8'h00; m_back[r] = 8'h00; end
      m_pend = 0; e_row = 8'hFF; e_col = 8'h00; e_fs = 0;
    end else begin
      acc  = hif.wr_valid && !m_pend;
      k    = k + 1;
      tick = (k % D) == 0;
      row  = ((k / D) - 1) % 8;
      bnd  = tick && (row == 0);
      if (acc) m_back[hif.wr_row] = hif.wr_data;
      if (bnd && m_pend) begin
        for (int r = 0; r < 8; r++) begin
          tmp = m_front[r]; m_front[r] = m_back[r]; m_back[r] = tmp;
        end
        m_pend = 0;
      end else if (!m_pend && hif.commit) begin
        m_pend = 1;
      end
      e_fs = bnd;
      if (tick) begin
        e_row = 8'hFF;
        e_row[7 - row] = 1'b0;
        e_col = m_front[row];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h k=%0d", tag, got, exp, k);
    end
  endtask

  task automatic check_all();
    logic [7:0] pin_row;
    pin_row = ((k % D) < BL) ? 8'hFF : e_row;
    chk("dot_row",        dot_row,                     pin_row);
    chk("dot_column",     dot_column,                  e_col);
    chk("frame_start",    {7'd0, frame_start},         {7'd0, e_fs});
    chk("commit_pending", {7'd0, hif.commit_pending},  {7'd0, m_pend});
    chk("wr_ready",       {7'd0, hif.wr_ready},        {7'd0, !m_pend});
  endtask

  // Inputs are set at the negedge; one call = one clock edge plus checks.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  function automatic bit next_is_bnd();
    int n;
    n = k + 1;
    return ((n % D) == 0) && ((((n / D) - 1) % 8) == 0);
  endfunction

  initial begin
    reset = 1'b1;
    hif.wr_valid = 1'b0; hif.wr_row = 3'd0; hif.wr_data = 8'h00; hif.commit = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5 * D) cyc();

    // Load a glyph into the back bank and commit it.
    for (int r = 0; r < 8; r++) begin
      hif.wr_valid = 1'b1; hif.wr_row = 3'(r); hif.wr_data = glyph[r];
      cyc();
    end
    hif.wr_valid = 1'b0;
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    repeat (20 * D) cyc();

    // Commit exactly on the row-7 tick, then a redundant commit while pending.
    hif.wr_valid = 1'b1; hif.wr_row = 3'd5; hif.wr_data = 8'h5A; cyc();
    hif.wr_valid = 1'b0;
    for (int i = 0; i < 8 * D + 2 && !next_is_bnd(); i++) cyc();
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    repeat (10) cyc();
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    repeat (20 * D) cyc();

    // Write held across a pending commit; lands in the new back bank later.
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    hif.wr_valid = 1'b1; hif.wr_row = 3'd3; hif.wr_data = 8'hAA;
    repeat (10 * D) cyc();
    hif.wr_valid = 1'b0;
    repeat (10 * D) cyc();
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    repeat (20 * D) cyc();

    // Random host traffic.
    repeat (100 * D) begin
      hif.wr_valid = 1'($urandom_range(0, 1));
      hif.wr_row   = 3'($urandom_range(0, 7));
      hif.wr_data  = 8'($urandom);
      hif.commit   = ($urandom_range(0, 15) == 0);
      cyc();
    end
    hif.wr_valid = 1'b0; hif.commit = 1'b0;

    // Reset mid-frame with a commit pending; display must come back blank.
    for (int r = 0; r < 8; r++) begin
      hif.wr_valid = 1'b1; hif.wr_row = 3'(r); hif.wr_data = 8'hFF; cyc();
    end
    hif.wr_valid = 1'b0;
    hif.commit = 1'b1; cyc(); hif.commit = 1'b0;
    repeat (3 * D + 1) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    repeat (20 * D) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
